// File: rtl/t02_wb_manager_pkg.sv
// Purpose: shared types and constants for the Wishbone manager slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package t02_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } wb_state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/t02_wb_manager_if.sv
// Purpose: Wishbone classic-cycle bus bundle between the manager and the SoC fabric.
// Latency: n/a (wires only).
// Backpressure: the slave holds off completion by withholding ACK_I.
interface t02_wb_manager_if;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic [31:0] DAT_I;
    logic        ACK_I;

    modport master (
        output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        input  DAT_I, ACK_I
    );

    modport slave (
        input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        output DAT_I, ACK_I
    );
endinterface

// File: rtl/t02_wb_timeout.sv
// Purpose: loadable up-counter that flags when the next count would reach TIMEOUT.
// Latency: expired is combinational from the current count and enable.
// Backpressure: none; the owner decides when to clear or enable.
module t02_wb_timeout #(
    parameter int TIMEOUT = 255,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          en,
    output logic          expired
);

    localparam logic [CW:0] LIMIT = (CW+1)'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Clear has priority over load, load over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expires on the cycle whose increment would land on TIMEOUT.
    assign expired = en && (({1'b0, cnt} + (CW+1)'(1)) == LIMIT);

endmodule

// File: rtl/t02_wb_manager.sv
// Purpose: turns a level-held RAM request into one Wishbone classic cycle at a time.
// Latency: request-to-ready is 2 cycles plus ACK wait states; aborts after TIMEOUT bus cycles.
// Backpressure: busy_o stays high from the request cycle until the one-cycle DONE state.
module t02_wb_manager
    import t02_pkg::*;
#(
    parameter int         TIMEOUT     = 255,
    parameter logic [3:0] SEL_DEFAULT = WB_SEL_ALL
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     Ren,
    input  logic                     Wen,
    input  logic [31:0]              ramaddr,
    input  logic [31:0]              ramstore,
    output logic [31:0]              ramload,
    output logic                     busy_o,
    output logic                     err_o,
    t02_wb_manager_if.master         wb
);

    localparam int CW = $clog2(TIMEOUT + 1);

    wb_state_t state;
    logic      req_vld;
    logic      tmo_clr;
    logic      tmo_en;
    logic      tmo_expired;

    // Ren=Wen=1 is the controller's idle code, so only an exclusive request counts.
    assign req_vld = Ren ^ Wen;
    assign tmo_clr = (state == IDLE) && req_vld;
    assign tmo_en  = (state == BUS) && !wb.ACK_I;

    t02_wb_timeout #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .clk     (clk),
        .rst     (RST),
        .clr     (tmo_clr),
        .ld      (1'b0),
        .ld_val  ('0),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // Sequencer and bus-side registers: latch on entry, freeze through BUS, release on ACK or timeout.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ramload  <= '0;
            wb.ADR_O <= '0;
            wb.DAT_O <= '0;
            wb.SEL_O <= '0;
            wb.WE_O  <= 1'b0;
            wb.STB_O <= 1'b0;
            wb.CYC_O <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        wb.ADR_O <= ramaddr;
                        wb.DAT_O <= Wen ? ramstore : 32'h0;
                        wb.WE_O  <= Wen;
                        wb.SEL_O <= SEL_DEFAULT;
                        wb.CYC_O <= 1'b1;
                        wb.STB_O <= 1'b1;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // ACK wins over a simultaneous expiry.
                    if (wb.ACK_I) begin
                        if (!wb.WE_O) begin
                            ramload <= wb.DAT_I;
                        end
                        wb.CYC_O <= 1'b0;
                        wb.STB_O <= 1'b0;
                        wb.WE_O  <= 1'b0;
                        state    <= DONE;
                    end else if (tmo_expired) begin
                        wb.CYC_O <= 1'b0;
                        wb.STB_O <= 1'b0;
                        wb.WE_O  <= 1'b0;
                        err_o    <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy mirrors the request in IDLE so the controller never sees a false ready.
    always_comb begin
        busy_o = 1'b0;
        case (state)
            IDLE:    busy_o = req_vld;
            BUS:     busy_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_t02_wb_manager.sv
// Purpose: self-checking bench for t02_wb_manager with a scripted Wishbone slave.
// Latency: checks request-to-ready against wait states and the timeout limit.
// Backpressure: drives ACK_I directly to model slave wait states.
module tb_t02_wb_manager;

    localparam int T = 4;

    logic        clk;
    logic        RST;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;
    logic        err_o;

    t02_wb_manager_if wb ();

    t02_wb_manager #(
        .TIMEOUT     (T),
        .SEL_DEFAULT (4'hF)
    ) dut (
        .clk      (clk),
        .RST      (RST),
        .Ren      (Ren),
        .Wen      (Wen),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .busy_o   (busy_o),
        .err_o    (err_o),
        .wb       (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] model_load;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] store;
        int          k;
        logic [31:0] dat;
        int          exp_bus;
        logic        exp_err;
        logic [31:0] exp_load;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request issued from IDLE; the slave ACKs in bus cycle k (k >= T never ACKs).
    task automatic run_txn(input logic rd, input logic [31:0] addr, input logic [31:0] store,
                           input int k, input logic [31:0] dat, input int exp_bus,
                           input logic exp_err, input logic [31:0] exp_load);
        int          nb;
        logic [31:0] exp_dat;
        exp_dat  = rd ? 32'h0 : store;
        Ren      = rd;
        Wen      = !rd;
        ramaddr  = addr;
        ramstore = store;
        wb.ACK_I = 1'b0;
        #1;
        chk("req_busy", 32'(busy_o), 32'd1);
        chk("req_cyc", 32'(wb.CYC_O), 32'd0);
        tick();
        Ren      = 1'b0;
        Wen      = 1'b0;
        ramaddr  = $urandom;
        ramstore = $urandom;
        nb       = 0;
        while (wb.CYC_O === 1'b1 && nb < 20) begin
            chk("bus_adr", wb.ADR_O, addr);
            chk("bus_dat", wb.DAT_O, exp_dat);
            chk("bus_we", 32'(wb.WE_O), 32'(!rd));
            chk("bus_sel", 32'(wb.SEL_O), 32'hF);
            chk("bus_stb", 32'(wb.STB_O), 32'd1);
            chk("bus_busy", 32'(busy_o), 32'd1);
            wb.ACK_I = (nb == k);
            wb.DAT_I = (nb == k) ? dat : $urandom;
            tick();
            nb++;
        end
        wb.ACK_I = 1'b0;
        chk("bus_cycles", 32'(nb), 32'(exp_bus));
        chk("done_busy", 32'(busy_o), 32'd0);
        chk("done_stb", 32'(wb.STB_O), 32'd0);
        chk("done_we", 32'(wb.WE_O), 32'd0);
        chk("done_err", 32'(err_o), 32'(exp_err));
        chk("done_load", ramload, exp_load);
        tick();
        chk("idle_err", 32'(err_o), 32'd0);
        chk("idle_cyc", 32'(wb.CYC_O), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_load", ramload, exp_load);
    endtask

    // Idle cycles with either idle encoding and stray ACK pulses that must be ignored.
    task automatic idle_cycles(input int n, input logic both_high);
        for (int i = 0; i < n; i++) begin
            Ren      = both_high;
            Wen      = both_high;
            ramaddr  = $urandom;
            wb.ACK_I = 1'($urandom_range(0, 1));
            wb.DAT_I = $urandom;
            #1;
            chk("idle_enc_busy", 32'(busy_o), 32'd0);
            chk("idle_enc_cyc", 32'(wb.CYC_O), 32'd0);
            tick();
        end
        wb.ACK_I = 1'b0;
        Ren      = 1'b0;
        Wen      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h3300_0010, 32'h0,         0, 32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF};
        tbl[1] = '{1'b0, 32'h3300_0020, 32'h1234_5678, 3, 32'hFFFF_0000, 4, 1'b0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 32'h3300_0030, 32'h0,         9, 32'h5555_5555, 4, 1'b1, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 32'h3300_0040, 32'h0,         2, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D};
        tbl[4] = '{1'b0, 32'h3300_0050, 32'hA5A5_A5A5, 0, 32'h1111_1111, 1, 1'b0, 32'hCAFE_F00D};
        tbl[5] = '{1'b1, 32'h3300_0060, 32'h0,         1, 32'h0000_0001, 2, 1'b0, 32'h0000_0001};
        tbl[6] = '{1'b1, 32'h3300_0070, 32'h0,         4, 32'h7777_7777, 4, 1'b1, 32'h0000_0001};

        RST      = 1'b1;
        Ren      = 1'b0;
        Wen      = 1'b0;
        ramaddr  = 32'h0;
        ramstore = 32'h0;
        wb.ACK_I = 1'b0;
        wb.DAT_I = 32'h0;
        #3;
        chk("rst_cyc", 32'(wb.CYC_O), 32'd0);
        chk("rst_stb", 32'(wb.STB_O), 32'd0);
        chk("rst_adr", wb.ADR_O, 32'h0);
        chk("rst_sel", 32'(wb.SEL_O), 32'h0);
        chk("rst_load", ramload, 32'h0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        tick();
        RST = 1'b0;
        tick();

        idle_cycles(10, 1'b1);
        idle_cycles(10, 1'b0);
        chk("idle_load_kept", ramload, 32'h0);

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i].rd, tbl[i].addr, tbl[i].store, tbl[i].k, tbl[i].dat,
                    tbl[i].exp_bus, tbl[i].exp_err, tbl[i].exp_load);
        end
        model_load = 32'h0000_0001;

        // Back-to-back: held Ren, address changes mid-BUS, ACK pulses outside BUS.
        Ren      = 1'b1;
        Wen      = 1'b0;
        ramaddr  = 32'h4400_0100;
        wb.ACK_I = 1'b0;
        tick();
        chk("b2b_cyc1", 32'(wb.CYC_O), 32'd1);
        ramaddr  = 32'h4400_0200;
        wb.ACK_I = 1'b1;
        wb.DAT_I = 32'hBEEF_0001;
        tick();
        chk("b2b_done_busy", 32'(busy_o), 32'd0);
        chk("b2b_done_adr", wb.ADR_O, 32'h4400_0100);
        chk("b2b_done_load", ramload, 32'hBEEF_0001);
        wb.DAT_I = 32'h0BAD_0BAD;
        tick();
        chk("b2b_idle_busy", 32'(busy_o), 32'd1);
        chk("b2b_idle_cyc", 32'(wb.CYC_O), 32'd0);
        tick();
        wb.ACK_I = 1'b0;
        chk("b2b_cyc2", 32'(wb.CYC_O), 32'd1);
        chk("b2b_adr2", wb.ADR_O, 32'h4400_0200);
        Ren = 1'b0;
        tick();
        chk("b2b_wait", 32'(wb.CYC_O), 32'd1);
        chk("b2b_load_hold", ramload, 32'hBEEF_0001);
        wb.ACK_I = 1'b1;
        wb.DAT_I = 32'hBEEF_0002;
        tick();
        wb.ACK_I = 1'b0;
        chk("b2b_done2_load", ramload, 32'hBEEF_0002);
        chk("b2b_done2_busy", 32'(busy_o), 32'd0);
        tick();

        // Reset while a read is in BUS.
        Ren     = 1'b1;
        ramaddr = 32'h5500_0000;
        tick();
        chk("mrst_pre_cyc", 32'(wb.CYC_O), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("mrst_cyc", 32'(wb.CYC_O), 32'd0);
        chk("mrst_stb", 32'(wb.STB_O), 32'd0);
        chk("mrst_we", 32'(wb.WE_O), 32'd0);
        chk("mrst_load", ramload, 32'h0);
        chk("mrst_err", 32'(err_o), 32'd0);
        Ren = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy_o), 32'd0);
        tick();
        RST = 1'b0;
        tick();
        chk("mrst_after_cyc", 32'(wb.CYC_O), 32'd0);
        chk("mrst_after_busy", 32'(busy_o), 32'd0);
        model_load = 32'h0;

        // Randomized traffic against the transaction-level latency/data rules.
        for (int n = 0; n < 40; n++) begin
            logic        rd;
            logic [31:0] addr;
            logic [31:0] store;
            logic [31:0] dat;
            int          k;
            int          eb;
            logic        ee;
            idle_cycles($urandom_range(0, 3), 1'($urandom_range(0, 1)));
            rd    = 1'($urandom_range(0, 1));
            addr  = $urandom;
            store = $urandom;
            dat   = $urandom;
            k     = $urandom_range(0, 6);
            ee    = (k >= T);
            eb    = ee ? T : k + 1;
            if (rd && !ee) begin
                model_load = dat;
            end
            run_txn(rd, addr, store, k, dat, eb, ee, model_load);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
